// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I size/sign encodings and controller states.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: store replication and byte enables, load extraction/extension, legality.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_f3,
  input  logic [1:0]       i_off,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [WIDTH-1:0] i_rdata,
  output logic [WIDTH-1:0] o_wdata,
  output logic [3:0]       o_be,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_legal
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[8*i_off +: 8];
  assign w_half = i_rdata[16*i_off[1] +: 16];

  always_comb begin
    o_legal = 1'b0;
    case (i_f3)
      F3_B, F3_BU: o_legal = 1'b1;
      F3_H, F3_HU: o_legal = ~i_off[0];
      F3_W:        o_legal = (i_off == 2'b00);
      default:     o_legal = 1'b0;
    endcase
  end

  // Stores replicate the datum into every lane; the byte enables pick the live one.
  always_comb begin
    o_wdata = i_wdata;
    o_be    = 4'hF;
    case (i_f3[1:0])
      2'b00: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_be    = 4'b0001 << i_off;
      end
      2'b01: begin
        o_wdata = {2{i_wdata[15:0]}};
        o_be    = 4'b0011 << i_off;
      end
      default: begin
        o_wdata = i_wdata;
        o_be    = 4'hF;
      end
    endcase
  end

  always_comb begin
    o_rdata = i_rdata;
    case (i_f3)
      F3_B:    o_rdata = {{(WIDTH-8){w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {{(WIDTH-8){1'b0}}, w_byte};
      F3_H:    o_rdata = {{(WIDTH-16){w_half[15]}}, w_half};
      F3_HU:   o_rdata = {{(WIDTH-16){1'b0}}, w_half};
      default: o_rdata = i_rdata;
    endcase
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: valid/ready request, response capture, pipeline stall and exception.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemReqM,
  input  logic             MemWriteM,
  input  logic [2:0]       Funct3M,
  input  logic [WIDTH-1:0] AddrM,
  input  logic [WIDTH-1:0] WriteDataM,
  output logic             StallM,
  output logic             ExcM,
  output logic [WIDTH-1:0] ReadDataW,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_rsp_valid,
  input  logic [WIDTH-1:0] mem_rdata
);
  lsu_state_t       r_state;
  logic [2:0]       r_f3;
  logic [1:0]       r_off;
  logic [2:0]       w_f3;
  logic [1:0]       w_off;
  logic [WIDTH-1:0] w_st_wdata;
  logic [WIDTH-1:0] w_ld_data;
  logic [3:0]       w_st_be;
  logic             w_legal;
  logic             w_idle_req;

  // The aligner sees live inputs in IDLE (legality, store format) and the latched access afterwards.
  assign w_f3  = (r_state == IDLE) ? Funct3M    : r_f3;
  assign w_off = (r_state == IDLE) ? AddrM[1:0] : r_off;

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .i_f3    (w_f3),
    .i_off   (w_off),
    .i_wdata (WriteDataM),
    .i_rdata (mem_rdata),
    .o_wdata (w_st_wdata),
    .o_be    (w_st_be),
    .o_rdata (w_ld_data),
    .o_legal (w_legal)
  );

  assign w_idle_req = rst_n && (r_state == IDLE) && MemReqM;
  assign ExcM       = w_idle_req && !w_legal;
  assign StallM     = (w_idle_req && w_legal) || (r_state == REQ) || (r_state == RSP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_f3          <= 3'b000;
      r_off         <= 2'b00;
      ReadDataW     <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= 4'h0;
    end else begin
      case (r_state)
        IDLE: if (MemReqM && w_legal) begin
          r_state       <= REQ;
          r_f3          <= Funct3M;
          r_off         <= AddrM[1:0];
          mem_req_valid <= 1'b1;
          mem_we        <= MemWriteM;
          mem_addr      <= {AddrM[WIDTH-1:2], 2'b00};
          mem_wdata     <= MemWriteM ? w_st_wdata : '0;
          mem_be        <= MemWriteM ? w_st_be : 4'hF;
        end
        REQ: if (mem_req_ready) begin
          mem_req_valid <= 1'b0;
          r_state       <= mem_we ? DONE : RSP;
        end
        RSP: if (mem_rsp_valid) begin
          ReadDataW <= w_ld_data;
          r_state   <= DONE;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: acts as the memory, counts stall cycles, checks alignment/extension.
module tb_lsu_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemReqM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] AddrM, WriteDataM;
  logic        StallM, ExcM;
  logic [31:0] ReadDataW;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_rsp_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .MemReqM(MemReqM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .AddrM(AddrM), .WriteDataM(WriteDataM), .StallM(StallM), .ExcM(ExcM), .ReadDataW(ReadDataW),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access with the bench acting as memory; returns the number of stalled cycles.
  task automatic access(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input int rdy_dly, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, output int stalls);
    int  wait_n = 0;
    bit  pend   = 0;
    bit  done   = 0;
    MemReqM = 1'b1; MemWriteM = we; Funct3M = f3; AddrM = addr; WriteDataM = wd;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'h5A5A5A5A;
    stalls = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!StallM) begin done = 1; break; end
      stalls++;
      mem_rsp_valid = pend;
      mem_rdata     = pend ? rd : 32'h5A5A5A5A;
      pend = 0;
      if (mem_req_valid) begin
        chk({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
        chk({tag, ".be"}, {28'd0, mem_be}, {28'd0, exp_be});
        chk({tag, ".wdata"}, mem_wdata, exp_wd);
        chk({tag, ".we"}, {31'd0, mem_we}, {31'd0, we});
        mem_req_ready = (wait_n >= rdy_dly);
        wait_n++;
        if (mem_req_ready && !we) pend = 1;
      end else begin
        mem_req_ready = 1'b0;
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $error("FAIL %s.timeout: observed no completion expected completion within 50 cycles", tag);
    end
    @(posedge clk); #1;
    MemReqM = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] rd, input logic [31:0] exp_rd, input int exp_stall);
    int st;
    access(tag, 1'b0, f3, addr, 32'h0, rd, 0, 4'hF, 32'h0, st);
    chk({tag, ".stall"}, st, exp_stall);
    chk({tag, ".rdata"}, ReadDataW, exp_rd);
  endtask

  task automatic store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int dly, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input int exp_stall, input logic [31:0] keep_rd);
    int st;
    access(tag, 1'b1, f3, addr, wd, 32'h0, dly, exp_be, exp_wd, st);
    chk({tag, ".stall"}, st, exp_stall);
    chk({tag, ".rdkeep"}, ReadDataW, keep_rd);
  endtask

  task automatic illegal(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr);
    MemReqM = 1'b1; MemWriteM = we; Funct3M = f3; AddrM = addr; WriteDataM = 32'h12345678;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".exc"}, {31'd0, ExcM}, 32'd1);
    chk({tag, ".stall"}, {31'd0, StallM}, 32'd0);
    @(posedge clk); #1;
    MemReqM = 1'b0;
    @(negedge clk);
    chk({tag, ".exc_clr"}, {31'd0, ExcM}, 32'd0);
    chk({tag, ".novalid"}, {31'd0, mem_req_valid}, 32'd0);
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; MemReqM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; AddrM = 32'h100;
    WriteDataM = 0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    #12;
    chk("rst.stall", {31'd0, StallM}, 32'd0);
    chk("rst.exc", {31'd0, ExcM}, 32'd0);
    chk("rst.valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst.rdata", ReadDataW, 32'd0);
    chk("rst.be", {28'd0, mem_be}, 32'd0);
    MemReqM = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    load("lw",  3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 3);
    load("lb",  3'b000, 32'h103, 32'h80112233, 32'hFFFFFF80, 3);
    load("lbu", 3'b100, 32'h103, 32'h80112233, 32'h00000080, 3);
    load("lb1", 3'b000, 32'h101, 32'h80112233, 32'h00000022, 3);
    load("lh",  3'b001, 32'h102, 32'h80011234, 32'hFFFF8001, 3);
    load("lhu", 3'b101, 32'h100, 32'h80011234, 32'h00001234, 3);

    store("sb", 3'b000, 32'h201, 32'h000000AB, 3, 4'b0010, 32'hABABABAB, 5, 32'h00001234);
    store("sh", 3'b001, 32'h202, 32'h1234CAFE, 0, 4'b1100, 32'hCAFECAFE, 2, 32'h00001234);
    store("sw", 3'b010, 32'h204, 32'h11223344, 1, 4'hF, 32'h11223344, 3, 32'h00001234);

    illegal("exc_lw",  1'b0, 3'b010, 32'h102);
    illegal("exc_f3",  1'b0, 3'b011, 32'h100);
    illegal("exc_lh",  1'b0, 3'b001, 32'h101);
    illegal("exc_sh",  1'b1, 3'b001, 32'h203);

    // Drive a load into RSP, then reset before the response arrives.
    MemReqM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; AddrM = 32'h300; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    chk("rsp.stall", {31'd0, StallM}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rrst.stall", {31'd0, StallM}, 32'd0);
    chk("rrst.valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rrst.rdata", ReadDataW, 32'd0);
    chk("rrst.addr", mem_addr, 32'd0);
    chk("rrst.wdata", mem_wdata, 32'd0);
    MemReqM = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rdata = 32'hCCCCCCCC;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("late.rdata", ReadDataW, 32'd0);
    chk("late.stall", {31'd0, StallM}, 32'd0);
    @(posedge clk); #1;
    load("lw2", 3'b010, 32'h300, 32'h0BADF00D, 32'h0BADF00D, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
